// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants and state encoding for the UART command parser.
// Opcodes, FSM states and the fixed ALU operand register addresses.
package uart_cmd_parser_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_OP_A    = 3'd4,
        ST_OP_B    = 3'd5,
        ST_ALU_FUN = 3'd6
    } state_e;

    // States in which the ALU clock must already be running.
    function automatic logic is_alu_state(input state_e s);
        return (s == ST_OP_A) || (s == ST_OP_B) || (s == ST_ALU_FUN);
    endfunction

endpackage

// File: rtl/uart_cmd_parser_timeout.sv
// Inter-byte idle counter for the command parser.
// Counts while enabled, flags the last allowed idle cycle.
module cmd_timeout_counter
    import uart_cmd_parser_pkg::*;
#(
    parameter int unsigned LIMIT     = 50000,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic hit
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = en && (cnt_q == CNT_WIDTH'(LIMIT - 1));

endmodule

// File: rtl/uart_cmd_parser.sv
// Byte-stream command parser between the UART receiver and the
// register file / ALU; emits registered one-cycle strobes.
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned FUN_WIDTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    input  logic                  rx_error,
    output logic                  rf_wr_en,
    output logic                  rf_rd_en,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    output logic                  alu_en,
    output logic [FUN_WIDTH-1:0]  alu_fun,
    output logic                  alu_clk_en,
    output logic                  busy,
    output logic                  cmd_err
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  rf_wr_en_q, rf_wr_en_d;
    logic                  rf_rd_en_q, rf_rd_en_d;
    logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;
    logic                  alu_en_q, alu_en_d;
    logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
    logic                  alu_clk_en_q, alu_clk_en_d;
    logic                  cmd_err_q, cmd_err_d;

    logic tmo_en;
    logic tmo_clr;
    logic tmo_hit;

    assign tmo_en  = (state_q != ST_IDLE);
    assign tmo_clr = (state_q == ST_IDLE) || rx_valid || tmo_hit;

    cmd_timeout_counter #(
        .LIMIT     (TIMEOUT_CYCLES),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .en  (tmo_en),
        .clr (tmo_clr),
        .hit (tmo_hit)
    );

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        rf_wr_en_d   = 1'b0;
        rf_rd_en_d   = 1'b0;
        rf_addr_d    = rf_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        alu_en_d     = 1'b0;
        alu_fun_d    = alu_fun_q;
        cmd_err_d    = 1'b0;

        if (rx_valid && rx_error) begin
            state_d   = ST_IDLE;
            cmd_err_d = 1'b1;
        end else if (rx_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    unique case (1'b1)
                        rx_data == DATA_WIDTH'(CMD_RF_WR):   state_d = ST_WR_ADDR;
                        rx_data == DATA_WIDTH'(CMD_RF_RD):   state_d = ST_RD_ADDR;
                        rx_data == DATA_WIDTH'(CMD_ALU_OP):  state_d = ST_OP_A;
                        rx_data == DATA_WIDTH'(CMD_ALU_NOP): state_d = ST_ALU_FUN;
                        default:                             cmd_err_d = 1'b1;
                    endcase
                end
                ST_WR_ADDR: begin
                    wr_addr_d = rx_data[ADDR_WIDTH-1:0];
                    state_d   = ST_WR_DATA;
                end
                ST_WR_DATA: begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = wr_addr_q;
                    rf_wr_data_d = rx_data;
                    state_d      = ST_IDLE;
                end
                ST_RD_ADDR: begin
                    rf_rd_en_d = 1'b1;
                    rf_addr_d  = rx_data[ADDR_WIDTH-1:0];
                    state_d    = ST_IDLE;
                end
                ST_OP_A: begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = ADDR_WIDTH'(OPA_ADDR);
                    rf_wr_data_d = rx_data;
                    state_d      = ST_OP_B;
                end
                ST_OP_B: begin
                    rf_wr_en_d   = 1'b1;
                    rf_addr_d    = ADDR_WIDTH'(OPB_ADDR);
                    rf_wr_data_d = rx_data;
                    state_d      = ST_ALU_FUN;
                end
                ST_ALU_FUN: begin
                    alu_en_d  = 1'b1;
                    alu_fun_d = rx_data[FUN_WIDTH-1:0];
                    state_d   = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (tmo_hit) begin
            state_d   = ST_IDLE;
            cmd_err_d = 1'b1;
        end

        // Clock runs while an ALU frame is open, on alu_en and one cycle after.
        alu_clk_en_d = is_alu_state(state_d) || alu_en_d || alu_en_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            wr_addr_q    <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_en_q   <= 1'b0;
            rf_addr_q    <= '0;
            rf_wr_data_q <= '0;
            alu_en_q     <= 1'b0;
            alu_fun_q    <= '0;
            alu_clk_en_q <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_en_q   <= rf_rd_en_d;
            rf_addr_q    <= rf_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            alu_en_q     <= alu_en_d;
            alu_fun_q    <= alu_fun_d;
            alu_clk_en_q <= alu_clk_en_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    assign rf_wr_en   = rf_wr_en_q;
    assign rf_rd_en   = rf_rd_en_q;
    assign rf_addr    = rf_addr_q;
    assign rf_wr_data = rf_wr_data_q;
    assign alu_en     = alu_en_q;
    assign alu_fun    = alu_fun_q;
    assign alu_clk_en = alu_clk_en_q;
    assign busy       = (state_q != ST_IDLE);
    assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed table, corner
// sequences and random traffic against a frame-level reference model.
module tb_uart_cmd_parser;

    localparam int TO = 20;

    typedef struct packed {
        logic       wr;
        logic       rd;
        logic       alu;
        logic       err;
        logic       clk_en;
        logic       busy;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [3:0] fun;
    } outs_t;

    typedef struct packed {
        logic       v;
        logic       e;
        logic [7:0] d;
        outs_t      exp;
    } row_t;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic       rf_wr_en;
    logic       rf_rd_en;
    logic [3:0] rf_addr;
    logic [7:0] rf_wr_data;
    logic       alu_en;
    logic [3:0] alu_fun;
    logic       alu_clk_en;
    logic       busy;
    logic       cmd_err;

    int checks;
    int failures;

    uart_cmd_parser #(
        .DATA_WIDTH     (8),
        .ADDR_WIDTH     (4),
        .FUN_WIDTH      (4),
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_error   (rx_error),
        .rf_wr_en   (rf_wr_en),
        .rf_rd_en   (rf_rd_en),
        .rf_addr    (rf_addr),
        .rf_wr_data (rf_wr_data),
        .alu_en     (alu_en),
        .alu_fun    (alu_fun),
        .alu_clk_en (alu_clk_en),
        .busy       (busy),
        .cmd_err    (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bytes of the open frame, idle gap, held outputs.
    outs_t      m;
    logic       in_frame;
    logic [7:0] op;
    int         nbytes;
    logic [7:0] addr_byte;
    int         idle;
    logic       alu_prev;

    function automatic string fmt(input outs_t o);
        return $sformatf("wr=%0b rd=%0b alu=%0b err=%0b clk_en=%0b busy=%0b addr=%h wdata=%h fun=%h",
                         o.wr, o.rd, o.alu, o.err, o.clk_en, o.busy, o.addr, o.wdata, o.fun);
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.wr     = rf_wr_en;
        o.rd     = rf_rd_en;
        o.alu    = alu_en;
        o.err    = cmd_err;
        o.clk_en = alu_clk_en;
        o.busy   = busy;
        o.addr   = rf_addr;
        o.wdata  = rf_wr_data;
        o.fun    = alu_fun;
        return o;
    endfunction

    task automatic check_outs(input string name, input outs_t act, input outs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: got %s want %s", name, $time, fmt(act), fmt(exp));
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m         = '0;
        in_frame  = 1'b0;
        op        = 8'h00;
        nbytes    = 0;
        addr_byte = 8'h00;
        idle      = 0;
        alu_prev  = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic e, input logic [7:0] d);
        m.wr  = 1'b0;
        m.rd  = 1'b0;
        m.alu = 1'b0;
        m.err = 1'b0;
        if (v && e) begin
            m.err    = 1'b1;
            in_frame = 1'b0;
        end else if (v) begin
            idle = 0;
            if (!in_frame) begin
                if (d inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) begin
                    in_frame = 1'b1;
                    op       = d;
                    nbytes   = 0;
                end else begin
                    m.err = 1'b1;
                end
            end else begin
                nbytes++;
                case (op)
                    8'hAA: begin
                        if (nbytes == 1) begin
                            addr_byte = d;
                        end else begin
                            m.wr     = 1'b1;
                            m.addr   = addr_byte[3:0];
                            m.wdata  = d;
                            in_frame = 1'b0;
                        end
                    end
                    8'hBB: begin
                        m.rd     = 1'b1;
                        m.addr   = d[3:0];
                        in_frame = 1'b0;
                    end
                    8'hCC: begin
                        if (nbytes < 3) begin
                            m.wr    = 1'b1;
                            m.addr  = (nbytes == 1) ? 4'd0 : 4'd1;
                            m.wdata = d;
                        end else begin
                            m.alu    = 1'b1;
                            m.fun    = d[3:0];
                            in_frame = 1'b0;
                        end
                    end
                    default: begin
                        m.alu    = 1'b1;
                        m.fun    = d[3:0];
                        in_frame = 1'b0;
                    end
                endcase
            end
        end else if (in_frame) begin
            idle++;
            if (idle == TO) begin
                m.err    = 1'b1;
                in_frame = 1'b0;
            end
        end
        m.busy   = in_frame;
        m.clk_en = (in_frame && (op == 8'hCC || op == 8'hDD)) || m.alu || alu_prev;
        alu_prev = m.alu;
    endtask

    // One clock: drive inputs, advance model on the edge, sample 1 ns later.
    task automatic step(input logic v, input logic e, input logic [7:0] d);
        rx_valid = v;
        rx_error = e;
        rx_data  = d;
        @(posedge clk);
        model_step(v, e, d);
        #1;
        rx_valid = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic step_chk(input logic v, input logic e, input logic [7:0] d);
        step(v, e, d);
        check_outs("model", sample(), m);
    endtask

    task automatic add_row(input logic v, input logic e, input logic [7:0] d,
                           input logic wr, input logic rd, input logic alu,
                           input logic err, input logic ce, input logic bsy,
                           input logic [3:0] a, input logic [7:0] wd,
                           input logic [3:0] f, inout row_t q[$]);
        row_t r;
        r.v   = v;
        r.e   = e;
        r.d   = d;
        r.exp = '{wr, rd, alu, err, ce, bsy, a, wd, f};
        q.push_back(r);
    endtask

    initial begin
        row_t rows[$];
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_error = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", sample(), '0);
        rst = 1'b1;

        //       v  e  d       wr rd al er ce by addr wdata fun
        add_row(1, 0, 8'hAA,  0, 0, 0, 0, 0, 1, 4'h0, 8'h00, 4'h0, rows);
        add_row(1, 0, 8'h05,  0, 0, 0, 0, 0, 1, 4'h0, 8'h00, 4'h0, rows);
        add_row(1, 0, 8'h3C,  1, 0, 0, 0, 0, 0, 4'h5, 8'h3C, 4'h0, rows);
        add_row(0, 0, 8'h00,  0, 0, 0, 0, 0, 0, 4'h5, 8'h3C, 4'h0, rows);
        add_row(1, 0, 8'hCC,  0, 0, 0, 0, 1, 1, 4'h5, 8'h3C, 4'h0, rows);
        add_row(1, 0, 8'h12,  1, 0, 0, 0, 1, 1, 4'h0, 8'h12, 4'h0, rows);
        add_row(1, 0, 8'h34,  1, 0, 0, 0, 1, 1, 4'h1, 8'h34, 4'h0, rows);
        add_row(1, 0, 8'h01,  0, 0, 1, 0, 1, 0, 4'h1, 8'h34, 4'h1, rows);
        add_row(0, 0, 8'h00,  0, 0, 0, 0, 1, 0, 4'h1, 8'h34, 4'h1, rows);
        add_row(0, 0, 8'h00,  0, 0, 0, 0, 0, 0, 4'h1, 8'h34, 4'h1, rows);
        add_row(1, 0, 8'h7E,  0, 0, 0, 1, 0, 0, 4'h1, 8'h34, 4'h1, rows);
        add_row(1, 0, 8'hBB,  0, 0, 0, 0, 0, 1, 4'h1, 8'h34, 4'h1, rows);
        add_row(1, 0, 8'h0F,  0, 1, 0, 0, 0, 0, 4'hF, 8'h34, 4'h1, rows);
        add_row(0, 0, 8'h00,  0, 0, 0, 0, 0, 0, 4'hF, 8'h34, 4'h1, rows);
        add_row(1, 0, 8'hAA,  0, 0, 0, 0, 0, 1, 4'hF, 8'h34, 4'h1, rows);
        add_row(1, 0, 8'h02,  0, 0, 0, 0, 0, 1, 4'hF, 8'h34, 4'h1, rows);
        add_row(1, 1, 8'h55,  0, 0, 0, 1, 0, 0, 4'hF, 8'h34, 4'h1, rows);
        add_row(1, 0, 8'hDD,  0, 0, 0, 0, 1, 1, 4'hF, 8'h34, 4'h1, rows);
        add_row(1, 0, 8'h08,  0, 0, 1, 0, 1, 0, 4'hF, 8'h34, 4'h8, rows);
        add_row(0, 0, 8'h00,  0, 0, 0, 0, 1, 0, 4'hF, 8'h34, 4'h8, rows);
        add_row(0, 0, 8'h00,  0, 0, 0, 0, 0, 0, 4'hF, 8'h34, 4'h8, rows);

        foreach (rows[i]) begin
            step(rows[i].v, rows[i].e, rows[i].d);
            check_outs($sformatf("table[%0d]", i), sample(), rows[i].exp);
        end

        // Timeout: opcode then TO idle cycles aborts the frame.
        step_chk(1, 0, 8'hBB);
        repeat (TO - 1) step_chk(0, 0, 8'h00);
        check_val("tmo_busy_before", {30'd0, busy, cmd_err}, 32'h2);
        step_chk(0, 0, 8'h00);
        check_val("tmo_abort", {30'd0, busy, cmd_err}, 32'h1);
        step_chk(0, 0, 8'h00);

        // Address byte on the limit cycle is still accepted.
        step_chk(1, 0, 8'hBB);
        repeat (TO - 1) step_chk(0, 0, 8'h00);
        step_chk(1, 0, 8'h03);
        check_val("limit_byte", {26'd0, rf_rd_en, cmd_err, rf_addr}, {26'd0, 2'b10, 4'h3});
        step_chk(0, 0, 8'h00);

        // Reset in the middle of an ALU frame.
        step_chk(1, 0, 8'hCC);
        step_chk(1, 0, 8'h11);
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset_mid", sample(), '0);
        rst = 1'b1;
        step_chk(1, 0, 8'hDD);
        step_chk(1, 0, 8'h03);
        check_val("post_reset_alu", {27'd0, alu_en, alu_fun}, {27'd0, 1'b1, 4'h3});
        step_chk(0, 0, 8'h00);
        step_chk(0, 0, 8'h00);

        // Random traffic with occasional long gaps to hit the timeout.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 3) begin
                int gap;
                gap = int'($urandom_range(TO - 5, TO + 4));
                for (int g = 0; g < gap; g++) step_chk(0, 0, 8'h00);
            end else begin
                logic       v;
                logic       e;
                logic [7:0] d;
                int         pick;
                v    = ($urandom_range(0, 9) < 6);
                e    = v && ($urandom_range(0, 29) == 0);
                pick = int'($urandom_range(0, 9));
                case (pick)
                    0, 1:    d = 8'hAA;
                    2:       d = 8'hBB;
                    3:       d = 8'hCC;
                    4:       d = 8'hDD;
                    default: d = 8'($urandom_range(0, 255));
                endcase
                step_chk(v, e, d);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
